// File: rtl/puf_query_ctrl_if.sv
// rtl/puf_query_ctrl_if.sv - challenge request and result response bundle for puf_query_ctrl
interface puf_query_ctrl_if #(
  parameter int N = 64
);
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req_chal;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_chal;
  logic         rsp_bit;
  logic [7:0]   rsp_ones;
  logic         rsp_unstable;

  modport slave (
    input  req_valid, req_chal, rsp_ready,
    output req_ready, rsp_valid, rsp_chal, rsp_bit, rsp_ones, rsp_unstable
  );

  modport master (
    output req_valid, req_chal, rsp_ready,
    input  req_ready, rsp_valid, rsp_chal, rsp_bit, rsp_ones, rsp_unstable
  );
endinterface

// File: rtl/puf_query_ctrl.sv
// rtl/puf_query_ctrl.sv - arbiter PUF sequencer: K timed launches, majority vote and stability flag
module puf_query_ctrl #(
  parameter int N      = 64,
  parameter int K      = 5,
  parameter int SETTLE = 4,
  parameter int REARM  = 2
) (
  input  logic            clk,
  input  logic            rstn,
  puf_query_ctrl_if.slave rq,
  input  logic            abort,
  output logic [N-1:0]    puf_chal,
  output logic            puf_launch,
  input  logic            puf_resp,
  output logic            busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_REARM,
    ST_FINISH,
    ST_DONE
  } state_t;

  localparam logic [7:0] LAST_REP   = 8'(K - 1);
  localparam logic [7:0] SETTLE_END = 8'(SETTLE);
  localparam logic [7:0] REARM_END  = 8'(REARM - 1);
  localparam logic [7:0] MAJ        = 8'((K + 1) / 2);
  localparam logic [7:0] K_C        = 8'(K);

  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [7:0]   rep_q, rep_d;
  logic [7:0]   ones_q, ones_d;
  logic [N-1:0] chal_q, chal_d;
  logic         launch_q, launch_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [N-1:0] rsp_chal_q, rsp_chal_d;
  logic         rsp_bit_q, rsp_bit_d;
  logic [7:0]   rsp_ones_q, rsp_ones_d;
  logic         rsp_unst_q, rsp_unst_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rep_q       <= '0;
      ones_q      <= '0;
      chal_q      <= '0;
      launch_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_chal_q  <= '0;
      rsp_bit_q   <= 1'b0;
      rsp_ones_q  <= '0;
      rsp_unst_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rep_q       <= rep_d;
      ones_q      <= ones_d;
      chal_q      <= chal_d;
      launch_q    <= launch_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_chal_q  <= rsp_chal_d;
      rsp_bit_q   <= rsp_bit_d;
      rsp_ones_q  <= rsp_ones_d;
      rsp_unst_q  <= rsp_unst_d;
    end
  end

  // launch_d is the value puf_launch takes after this edge; it defaults low so
  // only the acceptance and end-of-rearm paths can raise it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rep_d       = rep_q;
    ones_d      = ones_q;
    chal_d      = chal_q;
    launch_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_chal_d  = rsp_chal_q;
    rsp_bit_d   = rsp_bit_q;
    rsp_ones_d  = rsp_ones_q;
    rsp_unst_d  = rsp_unst_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rq.req_valid) begin
          chal_d   = rq.req_chal;
          cnt_d    = '0;
          rep_d    = '0;
          ones_d   = '0;
          launch_d = 1'b1;
          state_d  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        launch_d = 1'b1;
        if (cnt_q == SETTLE_END) begin
          ones_d   = ones_q + 8'(puf_resp);
          cnt_d    = '0;
          launch_d = 1'b0;
          if (rep_q == LAST_REP) begin
            state_d = ST_FINISH;
          end else begin
            rep_d   = rep_q + 8'd1;
            state_d = ST_REARM;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_REARM: begin
        if (cnt_q == REARM_END) begin
          cnt_d    = '0;
          launch_d = 1'b1;
          state_d  = ST_LAUNCH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_FINISH: begin
        rsp_valid_d = 1'b1;
        rsp_chal_d  = chal_q;
        rsp_ones_d  = ones_q;
        rsp_bit_d   = (ones_q >= MAJ);
        rsp_unst_d  = (ones_q != 8'd0) && (ones_q != K_C);
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (rq.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Cancel wins over everything, including a response handshake in DONE.
    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      launch_d    = 1'b0;
      rsp_valid_d = 1'b0;
    end
  end

  assign rq.req_ready    = rstn && (state_q == ST_IDLE);
  assign rq.rsp_valid    = rsp_valid_q;
  assign rq.rsp_chal     = rsp_chal_q;
  assign rq.rsp_bit      = rsp_bit_q;
  assign rq.rsp_ones     = rsp_ones_q;
  assign rq.rsp_unstable = rsp_unst_q;
  assign puf_chal        = chal_q;
  assign puf_launch      = launch_q;
  assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_puf_query_ctrl.sv
// tb/tb_puf_query_ctrl.sv - directed bench for puf_query_ctrl (default and K=1 configurations)
module tb_puf_query_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Default configuration
  puf_query_ctrl_if #(.N(64)) rq ();
  logic        abort = 1'b0;
  logic [63:0] puf_chal;
  logic        puf_launch;
  logic        puf_resp;
  logic        busy;

  puf_query_ctrl #(.N(64), .K(5), .SETTLE(4), .REARM(2)) dut (
    .clk(clk), .rstn(rstn), .rq(rq.slave), .abort(abort),
    .puf_chal(puf_chal), .puf_launch(puf_launch), .puf_resp(puf_resp), .busy(busy)
  );

  // K=1, SETTLE=1, REARM=1 configuration
  puf_query_ctrl_if #(.N(64)) rq2 ();
  logic        abort2 = 1'b0;
  logic [63:0] puf_chal2;
  logic        puf_launch2;
  logic        puf_resp2 = 1'b0;
  logic        busy2;

  puf_query_ctrl #(.N(64), .K(1), .SETTLE(1), .REARM(1)) dut2 (
    .clk(clk), .rstn(rstn), .rq(rq2.slave), .abort(abort2),
    .puf_chal(puf_chal2), .puf_launch(puf_launch2), .puf_resp(puf_resp2), .busy(busy2)
  );

  // PUF stub and launch-waveform monitor: pat bit i is the response to evaluation i
  logic [7:0] pat = 8'h00;
  logic       stat_clr = 1'b0;
  logic       launch_prev = 1'b0;
  int rises, hi_run, lo_run, hi_min, hi_max, gap_min, gap_max;
  logic seen_fall;

  always_comb puf_resp = (rises > 0) ? pat[3'(rises - 1)] : 1'b0;

  always @(posedge clk) begin
    if (stat_clr) begin
      launch_prev <= 1'b0;
      rises <= 0; hi_run <= 0; lo_run <= 0;
      hi_min <= 255; hi_max <= 0; gap_min <= 255; gap_max <= 0;
      seen_fall <= 1'b0;
    end else begin
      launch_prev <= puf_launch;
      if (puf_launch) begin
        hi_run <= launch_prev ? hi_run + 1 : 1;
        if (!launch_prev) begin
          rises <= rises + 1;
          if (seen_fall) begin
            if (lo_run < gap_min) gap_min <= lo_run;
            if (lo_run > gap_max) gap_max <= lo_run;
          end
        end
      end else begin
        lo_run <= launch_prev ? 1 : lo_run + 1;
        if (launch_prev) begin
          seen_fall <= 1'b1;
          if (hi_run < hi_min) hi_min <= hi_run;
          if (hi_run > hi_max) hi_max <= hi_run;
        end
      end
    end
  end

  task automatic start_query(input logic [63:0] chal, input logic [7:0] p, input string tag);
    @(negedge clk);
    pat = p;
    stat_clr = 1'b1;
    rq.req_valid = 1'b1;
    rq.req_chal = chal;
    chk({tag, "_req_ready"}, rq.req_ready, 1'b1);
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    rq.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (rq.rsp_valid) break;
    end
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    rq.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rq.rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, rq.rsp_valid, 1'b0);
    chk({tag, "_idle_ready"}, rq.req_ready, 1'b1);
  endtask

  task automatic check_result(input string tag, input logic [63:0] chal, input logic [7:0] e_ones,
                              input logic e_bit, input logic e_unst);
    chk({tag, "_ones"}, rq.rsp_ones, e_ones);
    chk({tag, "_bit"}, rq.rsp_bit, e_bit);
    chk({tag, "_unstable"}, rq.rsp_unstable, e_unst);
    chk({tag, "_chal"}, rq.rsp_chal, chal);
    chk({tag, "_rises"}, rises, 5);
    chk({tag, "_hi_min"}, hi_min, 5);
    chk({tag, "_hi_max"}, hi_max, 5);
    chk({tag, "_gap_min"}, gap_min, 2);
    chk({tag, "_gap_max"}, gap_max, 2);
  endtask

  task automatic run_full(input string tag, input logic [63:0] chal, input logic [7:0] p,
                          input logic [7:0] e_ones, input logic e_bit, input logic e_unst);
    int lat;
    start_query(chal, p, tag);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_puf_chal"}, puf_chal, chal);
    wait_rsp(lat);
    chk({tag, "_latency"}, lat, 34);
    check_result(tag, chal, e_ones, e_bit, e_unst);
    consume(tag);
  endtask

  task automatic run_k1(input string tag, input logic resp, input logic [63:0] chal);
    int lat;
    @(negedge clk);
    puf_resp2 = resp;
    rq2.req_valid = 1'b1;
    rq2.req_chal = chal;
    @(posedge clk);
    #1;
    rq2.req_valid = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
      if (rq2.rsp_valid) break;
    end
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_ones"}, rq2.rsp_ones, {7'd0, resp});
    chk({tag, "_bit"}, rq2.rsp_bit, resp);
    chk({tag, "_unstable"}, rq2.rsp_unstable, 1'b0);
    chk({tag, "_chal"}, rq2.rsp_chal, chal);
    @(negedge clk);
    rq2.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rq2.rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, rq2.rsp_valid, 1'b0);
  endtask

  initial begin
    int lat;
    int bound;
    logic bad_stable, bad_ready, bad_launch;
    logic [63:0] hold_chal;
    logic [7:0]  hold_ones;

    rq.req_valid = 1'b0; rq.req_chal = '0; rq.rsp_ready = 1'b0;
    rq2.req_valid = 1'b0; rq2.req_chal = '0; rq2.rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_launch", puf_launch, 1'b0);
    chk("rst_puf_chal", puf_chal, 64'd0);
    chk("rst_rsp_valid", rq.rsp_valid, 1'b0);
    chk("rst_rsp_ones", rq.rsp_ones, 8'd0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_req_ready", rq.req_ready, 1'b1);

    // Majority vote across response patterns
    run_full("all_ones", 64'h0123_4567_89AB_CDEF, 8'b11111, 8'd5, 1'b1, 1'b0);
    run_full("p10100", 64'hDEAD_BEEF_0000_0001, 8'b00101, 8'd2, 1'b0, 1'b1);
    run_full("p11010", 64'h1111_2222_3333_4444, 8'b01011, 8'd3, 1'b1, 1'b1);
    run_full("all_zero", 64'hFFFF_FFFF_FFFF_FFFF, 8'b00000, 8'd0, 1'b0, 1'b0);

    // Response back-pressure with a waiting request
    start_query(64'hAAAA_5555_AAAA_5555, 8'b10001, "hold");
    wait_rsp(lat);
    chk("hold_latency", lat, 34);
    hold_chal = rq.rsp_chal;
    hold_ones = rq.rsp_ones;
    chk("hold_ones", hold_ones, 8'd2);
    @(negedge clk);
    rq.req_valid = 1'b1;
    rq.req_chal = 64'h0F0F_0F0F_F0F0_F0F0;
    bad_stable = 1'b0; bad_ready = 1'b0; bad_launch = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!rq.rsp_valid || rq.rsp_chal !== hold_chal || rq.rsp_ones !== hold_ones ||
          rq.rsp_bit !== 1'b0 || rq.rsp_unstable !== 1'b1) bad_stable = 1'b1;
      if (rq.req_ready) bad_ready = 1'b1;
      if (puf_launch) bad_launch = 1'b1;
    end
    chk("hold_rsp_stable", bad_stable, 1'b0);
    chk("hold_req_ready_low", bad_ready, 1'b0);
    chk("hold_no_launch", bad_launch, 1'b0);
    @(negedge clk);
    rq.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rq.rsp_ready = 1'b0;
    pat = 8'b11110;
    stat_clr = 1'b1;
    chk("hold_hs_rsp_drop", rq.rsp_valid, 1'b0);
    chk("hold_hs_req_ready", rq.req_ready, 1'b1);
    chk("hold_hs_not_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    rq.req_valid = 1'b0;
    chk("hold_next_busy", busy, 1'b1);
    chk("hold_next_launch", puf_launch, 1'b1);
    chk("hold_next_puf_chal", puf_chal, 64'h0F0F_0F0F_F0F0_F0F0);
    wait_rsp(lat);
    chk("hold_next_latency", lat, 34);
    check_result("hold_next", 64'h0F0F_0F0F_F0F0_F0F0, 8'd4, 1'b1, 1'b1);
    consume("hold_next");

    // Abort during the third launch window
    start_query(64'h1234_0000_0000_4321, 8'b11111, "abort");
    bound = 0;
    while (!(rises == 3 && puf_launch) && bound < 100) begin
      @(negedge clk);
      bound++;
    end
    chk("abort_reached_eval3", bound < 100, 1'b1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_launch_low", puf_launch, 1'b0);
    chk("abort_no_rsp", rq.rsp_valid, 1'b0);
    chk("abort_req_ready", rq.req_ready, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    chk("abort_still_no_rsp", rq.rsp_valid, 1'b0);

    // abort in IDLE is ignored and the request is still taken
    @(negedge clk);
    abort = 1'b1;
    start_query(64'h5A5A_5A5A_5A5A_5A5A, 8'b00001, "idle_abort");
    abort = 1'b0;
    chk("idle_abort_busy", busy, 1'b1);
    wait_rsp(lat);
    chk("idle_abort_latency", lat, 34);
    check_result("idle_abort", 64'h5A5A_5A5A_5A5A_5A5A, 8'd1, 1'b0, 1'b1);

    // abort beats rsp_ready in DONE
    @(negedge clk);
    abort = 1'b1;
    rq.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    rq.rsp_ready = 1'b0;
    chk("done_abort_rsp_drop", rq.rsp_valid, 1'b0);
    chk("done_abort_idle", busy, 1'b0);

    // Asynchronous reset mid-REARM
    start_query(64'h7777_8888_9999_AAAA, 8'b11111, "rst_rearm");
    bound = 0;
    while (!(rises == 1 && !puf_launch && busy) && bound < 100) begin
      @(negedge clk);
      bound++;
    end
    chk("rst_rearm_reached", bound < 100, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_rearm_launch", puf_launch, 1'b0);
    chk("rst_rearm_busy", busy, 1'b0);
    chk("rst_rearm_puf_chal", puf_chal, 64'd0);
    chk("rst_rearm_rsp_valid", rq.rsp_valid, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    run_full("after_rst1", 64'hCAFE_F00D_1234_5678, 8'b10110, 8'd3, 1'b1, 1'b1);

    // Asynchronous reset mid-DONE
    start_query(64'h0BAD_0BAD_0BAD_0BAD, 8'b11111, "rst_done");
    wait_rsp(lat);
    chk("rst_done_valid", rq.rsp_valid, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_done_rsp_valid", rq.rsp_valid, 1'b0);
    chk("rst_done_rsp_ones", rq.rsp_ones, 8'd0);
    chk("rst_done_rsp_bit", rq.rsp_bit, 1'b0);
    chk("rst_done_rsp_chal", rq.rsp_chal, 64'd0);
    chk("rst_done_busy", busy, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    run_full("after_rst2", 64'h0123_4567_89AB_CDEF, 8'b11111, 8'd5, 1'b1, 1'b0);

    // Single-evaluation configuration
    run_k1("k1_one", 1'b1, 64'h0000_0000_0000_00FF);
    run_k1("k1_zero", 1'b0, 64'hFF00_0000_0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
